// File: rtl/mem_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } arb_state_e;

   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_ADDR_W  = 8;
   localparam int DEF_DATA_W  = 8;
   localparam int DEF_MEM_LAT = 1;

   // Wide enough to count MEM_LAT-1 for latencies up to 4.
   localparam int LAT_CNT_W = 3;

   // Index width that stays at least one bit for a single requester.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: rotate the request vector so rr_ptr
// lands on bit 0, take the lowest set bit, then rotate the index back.
module rr_picker
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   localparam int IDX_W  = idx_width(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   rr_ptr,
   output logic               grant_valid,
   output logic [IDX_W-1:0]   grant_idx
);

   localparam int SUM_W = IDX_W + 1;

   logic [NUM_REQ-1:0] rotated;
   logic [SUM_W-1:0]   rot_sum;
   logic [IDX_W-1:0]   offset;
   logic [SUM_W-1:0]   idx_sum;

   // Rotate, priority-encode from bit 0 upwards, then undo the rotation.
   always_comb begin
      rotated = '0;
      rot_sum = '0;
      offset  = '0;
      idx_sum = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         rot_sum = SUM_W'(j) + SUM_W'(rr_ptr);
         if (rot_sum >= SUM_W'(NUM_REQ)) begin
            rot_sum = rot_sum - SUM_W'(NUM_REQ);
         end
         rotated[j] = req[rot_sum[IDX_W-1:0]];
      end
      for (int j = NUM_REQ - 1; j >= 0; j--) begin
         if (rotated[j]) begin
            offset = IDX_W'(j);
         end
      end
      idx_sum = SUM_W'(offset) + SUM_W'(rr_ptr);
      if (idx_sum >= SUM_W'(NUM_REQ)) begin
         idx_sum = idx_sum - SUM_W'(NUM_REQ);
      end
      grant_valid = |rotated;
      grant_idx   = idx_sum[IDX_W-1:0];
   end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter that serialises requester transactions onto one
// single-port memory and returns a one-hot completion pulse per requester.
module mem_rr_arbiter
   import mem_arb_pkg::*;
#(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int ADDR_W  = DEF_ADDR_W,
   parameter int DATA_W  = DEF_DATA_W,
   parameter int MEM_LAT = DEF_MEM_LAT
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ-1:0]        req_write,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [DATA_W-1:0]         rsp_rdata,
   output logic                      mem_enable,
   output logic                      mem_read,
   output logic                      mem_write,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [DATA_W-1:0]         mem_wdata,
   input  logic [DATA_W-1:0]         mem_rdata
);

   localparam int IDX_W = idx_width(NUM_REQ);

   arb_state_e           state_q;
   arb_state_e           state_d;
   logic [IDX_W-1:0]     rr_ptr;
   logic [IDX_W-1:0]     own_idx;
   logic                 lat_wr;
   logic [ADDR_W-1:0]    lat_addr;
   logic [DATA_W-1:0]    lat_wdata;
   logic [LAT_CNT_W-1:0] lat_cnt;
   logic                 grant_valid;
   logic [IDX_W-1:0]     grant_idx;
   logic                 grant_fire;

   rr_picker #(
      .NUM_REQ (NUM_REQ)
   ) u_picker (
      .req         (req_valid),
      .rr_ptr      (rr_ptr),
      .grant_valid (grant_valid),
      .grant_idx   (grant_idx)
   );

   // The memory always sees the latched request; strobes say when it counts.
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;

   // Next-state and strobe decode; grants only happen in IDLE and never in reset.
   always_comb begin
      state_d    = state_q;
      req_ready  = '0;
      rsp_valid  = '0;
      mem_enable = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      grant_fire = 1'b0;
      case (state_q)
         IDLE: begin
            if (grant_valid && !rst) begin
               req_ready[grant_idx] = 1'b1;
               grant_fire           = 1'b1;
               state_d              = ISSUE;
            end
         end
         ISSUE: begin
            mem_enable = 1'b1;
            mem_read   = ~lat_wr;
            mem_write  = lat_wr;
            state_d    = WAIT;
         end
         WAIT: begin
            if (lat_cnt == LAT_CNT_W'(MEM_LAT - 1)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            rsp_valid[own_idx] = 1'b1;
            state_d            = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State register; reset returns to IDLE and abandons any transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Latch the winning request, advance the pointer and time the memory access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr    <= '0;
         own_idx   <= '0;
         lat_wr    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_cnt   <= '0;
      end else begin
         if (grant_fire) begin
            own_idx   <= grant_idx;
            lat_wr    <= req_write[grant_idx];
            lat_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
            lat_wdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
            rr_ptr    <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
         end
         if (state_q == ISSUE) begin
            lat_cnt <= '0;
         end else if (state_q == WAIT) begin
            lat_cnt <= lat_cnt + 1'b1;
         end
      end
   end

   // Capture read data on the way into RESP so it is valid alongside rsp_valid.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_rdata <= '0;
      end else if (state_q == WAIT && state_d == RESP && !lat_wr) begin
         rsp_rdata <= mem_rdata;
      end
   end

endmodule
